// File: rtl/regfile_ctrl_if.sv
// -----------------------------------------------------------------------------
// regfile_ctrl_if
// Byte-wide command and response channels between a host and regfile_ctrl.
//
// Handshake: a byte moves on a rising clk edge where valid and ready are both
// high. The source holds valid and data stable until that edge. The sink may
// change ready freely. valid never waits on ready.
//
// Signals:
//   cmd_valid / cmd_ready / cmd_data[7:0]  host -> controller command bytes
//   rsp_valid / rsp_ready / rsp_data[7:0]  controller -> host response bytes
// Modports:
//   master : host side (drives cmd_*, rsp_ready)
//   slave  : controller side (drives cmd_ready, rsp_valid, rsp_data)
// -----------------------------------------------------------------------------
interface regfile_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;

    modport master (
        output cmd_valid, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/regfile_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_ctrl
// Command-driven controller for an external 8 x 4-bit register file.
// Command byte 1: [7:6] opcode (00 READ, 01 WRITE, 10 ADD, 11 CLEAR),
// [5:3] field A, [2:0] field B. WRITE and ADD take a second byte.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   bus           regfile_ctrl_if.slave (cmd/rsp byte channels)
//   rf_read_reg1  read address 1         rf_read_data1  async read data 1
//   rf_read_reg2  read address 2         rf_read_data2  async read data 2
//   rf_write_reg  write address          rf_write_data  write data
//   rf_we         write enable (taken by the register file at the next edge)
//   dbg_state     current FSM state
//
// Every rf_* and rsp_* output comes straight from a register. Address 0 is
// never written: a WRITE/ADD to register 0 still spends its WB cycle, with
// rf_we held low.
// -----------------------------------------------------------------------------
module regfile_ctrl #(
    parameter logic [7:0] ACK_CODE = 8'hA5
) (
    input  logic                clk,
    input  logic                rst_n,
    regfile_ctrl_if.slave       bus,
    output logic [2:0]          rf_read_reg1,
    output logic [2:0]          rf_read_reg2,
    input  logic [3:0]          rf_read_data1,
    input  logic [3:0]          rf_read_data2,
    output logic [2:0]          rf_write_reg,
    output logic [3:0]          rf_write_data,
    output logic                rf_we,
    output logic [2:0]          dbg_state
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARG  = 3'd1;
    localparam logic [2:0] S_EXEC = 3'd2;
    localparam logic [2:0] S_WB   = 3'd3;
    localparam logic [2:0] S_CLR  = 3'd4;
    localparam logic [2:0] S_RESP = 3'd5;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic [2:0] state_q, state_d;
    logic [1:0] op_q, op_d;
    logic [2:0] dest_q, dest_d;
    logic [4:0] sum_q, sum_d;
    logic [2:0] cnt_q, cnt_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic [2:0] rd1_q, rd1_d;
    logic [2:0] rd2_q, rd2_d;
    logic [2:0] wreg_q, wreg_d;
    logic [3:0] wdata_q, wdata_d;
    logic       we_q, we_d;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        dest_d      = dest_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rd1_d       = rd1_q;
        rd2_d       = rd2_q;
        wreg_d      = wreg_q;
        wdata_d     = wdata_q;
        we_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    op_d = bus.cmd_data[7:6];
                    case (bus.cmd_data[7:6])
                        OP_READ: begin
                            rd1_d   = bus.cmd_data[5:3];
                            rd2_d   = bus.cmd_data[2:0];
                            state_d = S_EXEC;
                        end
                        OP_WRITE, OP_ADD: begin
                            dest_d  = bus.cmd_data[5:3];
                            state_d = S_ARG;
                        end
                        default: begin
                            // CLEAR: first write (address 1) goes out on the
                            // very next cycle, so the sweep starts here.
                            cnt_d   = 3'd1;
                            we_d    = 1'b1;
                            wreg_d  = 3'd1;
                            wdata_d = 4'd0;
                            state_d = S_CLR;
                        end
                    endcase
                end
            end

            S_ARG: begin
                if (bus.cmd_valid) begin
                    if (op_q == OP_WRITE) begin
                        we_d    = (dest_q != 3'd0);
                        wreg_d  = dest_q;
                        wdata_d = bus.cmd_data[3:0];
                        state_d = S_WB;
                    end else begin
                        rd1_d   = bus.cmd_data[5:3];
                        rd2_d   = bus.cmd_data[2:0];
                        state_d = S_EXEC;
                    end
                end
            end

            S_EXEC: begin
                if (op_q == OP_READ) begin
                    rsp_data_d  = {rf_read_data2, rf_read_data1};
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    sum_d   = {1'b0, rf_read_data1} + {1'b0, rf_read_data2};
                    we_d    = (dest_q != 3'd0);
                    wreg_d  = dest_q;
                    wdata_d = sum_d[3:0];
                    state_d = S_WB;
                end
            end

            S_WB: begin
                if (op_q == OP_ADD) begin
                    rsp_data_d  = {3'b000, sum_q};
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_CLR: begin
                if (cnt_q == 3'd7) begin
                    rsp_data_d  = ACK_CODE;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    cnt_d   = cnt_q + 3'd1;
                    we_d    = 1'b1;
                    wreg_d  = cnt_q + 3'd1;
                    wdata_d = 4'd0;
                end
            end

            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= 2'd0;
            dest_q      <= 3'd0;
            sum_q       <= 5'd0;
            cnt_q       <= 3'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'd0;
            rd1_q       <= 3'd0;
            rd2_q       <= 3'd0;
            wreg_q      <= 3'd0;
            wdata_q     <= 4'd0;
            we_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            dest_q      <= dest_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rd1_q       <= rd1_d;
            rd2_q       <= rd2_d;
            wreg_q      <= wreg_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
        end
    end

    assign bus.cmd_ready = (state_q == S_IDLE) || (state_q == S_ARG);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign rf_read_reg1  = rd1_q;
    assign rf_read_reg2  = rd2_q;
    assign rf_write_reg  = wreg_q;
    assign rf_write_data = wdata_q;
    assign rf_we         = we_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_regfile_ctrl.sv
module tb_regfile_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] rf_read_reg1, rf_read_reg2, rf_write_reg, dbg_state;
    logic [3:0] rf_read_data1, rf_read_data2, rf_write_data;
    logic       rf_we;

    int checks = 0;
    int errors = 0;
    int we_zero_cnt = 0;

    logic [3:0] mem [8];

    regfile_ctrl_if bus ();

    regfile_ctrl #(.ACK_CODE(8'hA5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus.slave),
        .rf_read_reg1  (rf_read_reg1),
        .rf_read_reg2  (rf_read_reg2),
        .rf_read_data1 (rf_read_data1),
        .rf_read_data2 (rf_read_data2),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data),
        .rf_we         (rf_we),
        .dbg_state     (dbg_state)
    );

    // ---- clock ----
    always #5 clk = ~clk;

    // ---- register-file environment: async read, write at clock edge ----
    assign rf_read_data1 = mem[rf_read_reg1];
    assign rf_read_data2 = mem[rf_read_reg2];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) mem[i] <= 4'd0;
        end else if (rf_we) begin
            mem[rf_write_reg] <= rf_write_data;
        end
        if (rf_we && rf_write_reg == 3'd0) we_zero_cnt <= we_zero_cnt + 1;
    end

    // ---- checker ----
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---- driver tasks (called and returning at a falling edge) ----
    task automatic send_byte(input logic [7:0] b);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = b;
        chk("cmd_ready_before_send", bus.cmd_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic consume_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_after_consume", bus.rsp_valid, 1'b0);
        chk("state_idle_after_consume", dbg_state, 3'd0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'h00;
        bus.rsp_ready = 1'b0;
        idle_cycles(3);
        rst_n = 1'b1;

        // reset state
        chk("rst_state", dbg_state, 3'd0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_data", bus.rsp_data, 8'h00);
        chk("rst_we", rf_we, 1'b0);
        chk("rst_wreg", rf_write_reg, 3'd0);
        chk("rst_rd1", rf_read_reg1, 3'd0);
        chk("rst_cmd_ready", bus.cmd_ready, 1'b1);

        // WRITE 0x58, 0x09 -> r3 = 9; ARG holds while cmd_valid is low
        send_byte(8'h58);
        chk("wr_arg_state", dbg_state, 3'd1);
        idle_cycles(3);
        chk("wr_arg_hold_state", dbg_state, 3'd1);
        chk("wr_arg_hold_we", rf_we, 1'b0);
        send_byte(8'h09);
        chk("wr_we", rf_we, 1'b1);
        chk("wr_reg", rf_write_reg, 3'd3);
        chk("wr_data", rf_write_data, 4'd9);
        chk("wr_no_rsp", bus.rsp_valid, 1'b0);
        idle_cycles(1);
        chk("wr_we_one_cycle", rf_we, 1'b0);
        chk("wr_back_idle", dbg_state, 3'd0);
        chk("wr_mem3", mem[3], 4'd9);
        chk("wr_no_rsp2", bus.rsp_valid, 1'b0);

        // WRITE r5 = 4
        send_byte(8'h68);
        send_byte(8'h04);
        idle_cycles(1);
        chk("wr_mem5", mem[5], 4'd4);

        // READ 0x1D (A=3, B=5) -> 0x49, held while rsp_ready low
        send_byte(8'h1D);
        chk("rd_exec_state", dbg_state, 3'd2);
        chk("rd_rd1", rf_read_reg1, 3'd3);
        chk("rd_rd2", rf_read_reg2, 3'd5);
        chk("rd_no_rsp_yet", bus.rsp_valid, 1'b0);
        idle_cycles(1);
        for (int i = 0; i < 3; i++) begin
            chk("rd_rsp_valid_hold", bus.rsp_valid, 1'b1);
            chk("rd_rsp_data_hold", bus.rsp_data, 8'h49);
            chk("rd_cmd_ready_low", bus.cmd_ready, 1'b0);
            idle_cycles(1);
        end
        consume_rsp();

        // WRITE r5 = 9, then ADD dest 6 = r3 + r5 = 18 -> 2 carry 1
        send_byte(8'h68);
        send_byte(8'h09);
        idle_cycles(1);
        send_byte(8'hB0);
        send_byte(8'h1D);
        chk("add_exec_state", dbg_state, 3'd2);
        chk("add_rd1", rf_read_reg1, 3'd3);
        chk("add_rd2", rf_read_reg2, 3'd5);
        idle_cycles(1);
        chk("add_wb_state", dbg_state, 3'd3);
        chk("add_we", rf_we, 1'b1);
        chk("add_wreg", rf_write_reg, 3'd6);
        chk("add_wdata", rf_write_data, 4'd2);
        chk("add_no_rsp_yet", bus.rsp_valid, 1'b0);
        idle_cycles(1);
        chk("add_rsp_valid", bus.rsp_valid, 1'b1);
        chk("add_rsp_data", bus.rsp_data, 8'h12);
        chk("add_we_off", rf_we, 1'b0);
        chk("add_mem6", mem[6], 4'd2);
        consume_rsp();

        // ADD dest 0: WB cycle without write, response still carries sum
        send_byte(8'h80);
        send_byte(8'h1D);
        idle_cycles(1);
        chk("add0_wb_state", dbg_state, 3'd3);
        chk("add0_we", rf_we, 1'b0);
        idle_cycles(1);
        chk("add0_rsp_valid", bus.rsp_valid, 1'b1);
        chk("add0_rsp_data", bus.rsp_data, 8'h12);
        consume_rsp();

        // WRITE reg 0: WB cycle without write
        send_byte(8'h40);
        send_byte(8'h07);
        chk("wr0_wb_state", dbg_state, 3'd3);
        chk("wr0_we", rf_we, 1'b0);
        idle_cycles(1);
        chk("wr0_idle", dbg_state, 3'd0);

        // CLEAR: 7 writes to addresses 1..7 with data 0, then ACK
        send_byte(8'hC0);
        for (int i = 1; i <= 7; i++) begin
            chk("clr_we", rf_we, 1'b1);
            chk("clr_wreg", rf_write_reg, 32'(i));
            chk("clr_wdata", rf_write_data, 4'd0);
            chk("clr_no_rsp", bus.rsp_valid, 1'b0);
            idle_cycles(1);
        end
        chk("clr_we_off", rf_we, 1'b0);
        chk("clr_rsp_valid", bus.rsp_valid, 1'b1);
        chk("clr_rsp_data", bus.rsp_data, 8'hA5);
        chk("clr_mem3", mem[3], 4'd0);
        chk("clr_mem6", mem[6], 4'd0);
        consume_rsp();

        // CLEAR aborted by reset during its 4th write cycle
        send_byte(8'hC0);
        idle_cycles(3);
        chk("abort_4th_reg", rf_write_reg, 3'd4);
        rst_n = 1'b0;
        idle_cycles(1);
        rst_n = 1'b1;
        chk("abort_we", rf_we, 1'b0);
        chk("abort_state", dbg_state, 3'd0);
        chk("abort_cmd_ready", bus.cmd_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_rsp", bus.rsp_valid, 1'b0);
            chk("abort_no_we", rf_we, 1'b0);
            idle_cycles(1);
        end

        chk("never_we_reg0", we_zero_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: observed no finish expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
